// File: rtl/sprite_plotter_if.sv
// Request, sprite-ROM and pixel-port signals of the sprite plotter.
// master = game logic / ROM / VGA side, slave = plotter.
interface sprite_plotter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int AW       = 4
);
  logic                iStart;
  logic [1:0]          iMode;
  logic [X_W-1:0]      iX;
  logic [Y_W-1:0]      iY;
  logic [COLOUR_W-1:0] iColour;
  logic [AW-1:0]       oPixAddr;
  logic [COLOUR_W-1:0] iPixColour;
  logic [X_W-1:0]      oX;
  logic [Y_W-1:0]      oY;
  logic [COLOUR_W-1:0] oColour;
  logic                oPlot;
  logic                oBusy;
  logic                oDone;

  modport master (
    output iStart, iMode, iX, iY, iColour, iPixColour,
    input  oPixAddr, oX, oY, oColour, oPlot, oBusy, oDone
  );

  modport slave (
    input  iStart, iMode, iX, iY, iColour, iPixColour,
    output oPixAddr, oX, oY, oColour, oPlot, oBusy, oDone
  );
endinterface

// File: rtl/sprite_plotter.sv
// Sprite draw/erase/move/fill engine driving the VGA adapter pixel port.
// One pixel per clock, one pipeline stage so colour lines up with ROM data.
// Optional feature macro: SPRITE_TRANSP_EN (DRAW pixels equal to TRANSP are not plotted).
module sprite_plotter #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOUR_W  = 3,
  parameter int SPR_W     = 4,
  parameter int SPR_H     = 4,
  parameter int BG_COLOUR = 0,
  parameter int TRANSP    = 0
) (
  input logic             clock,
  input logic             reset,
  sprite_plotter_if.slave bus
);
  localparam int N  = SPR_W * SPR_H;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [1:0] M_DRAW  = 2'b00;
  localparam logic [1:0] M_ERASE = 2'b01;
  localparam logic [1:0] M_MOVE  = 2'b10;
  localparam logic [1:0] M_FILL  = 2'b11;

`ifdef SPRITE_TRANSP_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ERASE_PASS, DRAW_PASS, FLUSH, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [1:0]          mode_q;
  logic [X_W-1:0]      new_x, org_x, prev_x, out_x;
  logic [Y_W-1:0]      new_y, org_y, prev_y, out_y;
  logic [COLOUR_W-1:0] colour_q, pcol_q;
  logic                plot_q, rom_q;

  logic in_pass, last, load, hop;
  assign in_pass = (state == ERASE_PASS) || (state == DRAW_PASS);
  assign last    = (col == CW'(SPR_W-1)) && (row == RW'(SPR_H-1));
  assign load    = (state == IDLE) && bus.iStart;
  // MOVE chains its draw pass straight after the erase pass, no gap cycle
  assign hop     = (state == ERASE_PASS) && last && (mode_q == M_MOVE);

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: pass sequencing, then flush the pipeline stage, then one DONE cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (bus.iStart)
                    state_nxt = (bus.iMode == M_ERASE || bus.iMode == M_MOVE) ? ERASE_PASS : DRAW_PASS;
      ERASE_PASS: if (last) state_nxt = (mode_q == M_MOVE) ? DRAW_PASS : FLUSH;
      DRAW_PASS:  if (last) state_nxt = FLUSH;
      FLUSH:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // request latch, per-pass origin and previous-origin tracking
  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_q <= M_DRAW; colour_q <= '0;
      new_x  <= '0; new_y  <= '0;
      org_x  <= '0; org_y  <= '0;
      prev_x <= '0; prev_y <= '0;
    end else begin
      if (load) begin
        mode_q   <= bus.iMode;
        colour_q <= bus.iColour;
        new_x    <= bus.iX;
        new_y    <= bus.iY;
        org_x    <= (bus.iMode == M_MOVE) ? prev_x : bus.iX;
        org_y    <= (bus.iMode == M_MOVE) ? prev_y : bus.iY;
      end else if (hop) begin
        org_x <= new_x;
        org_y <= new_y;
      end
      if (state == DONE && mode_q != M_ERASE) begin
        prev_x <= new_x;
        prev_y <= new_y;
      end
    end
  end

  // raster counters: col fastest, row on col wrap, both back to 0 after the last pixel
  always_ff @(posedge clock) begin
    if (!reset || !in_pass) begin
      col <= '0;
      row <= '0;
    end else if (col == CW'(SPR_W-1)) begin
      col <= '0;
      row <= (row == RW'(SPR_H-1)) ? '0 : row + 1'b1;
    end else begin
      col <= col + 1'b1;
    end
  end

  // output stage, one clock behind the counters (same cycle as ROM data)
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_x <= '0; out_y <= '0; pcol_q <= '0;
      plot_q <= 1'b0; rom_q <= 1'b0;
    end else begin
      plot_q <= in_pass;
      rom_q  <= (state == DRAW_PASS) && (mode_q != M_FILL);
      pcol_q <= !in_pass ? '0 : (state == ERASE_PASS) ? COLOUR_W'(BG_COLOUR) : colour_q;
      if (in_pass) begin
        out_x <= org_x + X_W'(col);
        out_y <= org_y + Y_W'(row);
      end
    end
  end

  assign bus.oPixAddr = AW'(row * SPR_W + col);
  assign bus.oX       = out_x;
  assign bus.oY       = out_y;
  assign bus.oColour  = rom_q ? bus.iPixColour : pcol_q;
  assign bus.oPlot    = plot_q & ~(TRANSP_EN & rom_q & (bus.iPixColour == COLOUR_W'(TRANSP)));
  assign bus.oBusy    = in_pass || (state == FLUSH);
  assign bus.oDone    = (state == DONE);
endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: requests push expected pixels/done
// (tagged with the cycle they must appear in) and a monitor checks them.
module tb_sprite_plotter;
  localparam int X_W = 8, Y_W = 7, CW = 3, SW = 4, SH = 4, N = SW*SH, AW = 4;
  localparam logic [CW-1:0] BG = 3'd0;
  localparam logic [CW-1:0] TRANSP = 3'd0;
`ifdef SPRITE_TRANSP_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sprite_plotter_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(CW), .AW(AW)) bus ();

  sprite_plotter #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(CW), .SPR_W(SW), .SPR_H(SH),
                   .BG_COLOUR(0), .TRANSP(0)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  // synchronous sprite ROM: data one clock after the address
  logic [CW-1:0] rom [N];
  always @(posedge clock) bus.iPixColour <= rom[bus.oPixAddr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    bit             done;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [CW-1:0]  c;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;
  int k_start = 0, done_cyc = 0;
  logic [X_W-1:0] prev_x = '0;
  logic [Y_W-1:0] prev_y = '0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // expected pixels of one pass, row-major, coordinates wrap modulo 2^W
  task automatic push_pass(bit erase, bit fill, logic [X_W-1:0] ox, logic [Y_W-1:0] oy,
                           logic [CW-1:0] colour, int base);
    for (int p = 0; p < N; p++) begin
      exp_t e;
      logic [CW-1:0] c;
      c = erase ? BG : fill ? colour : rom[p];
      e.cyc = base + p; e.done = 1'b0;
      e.x = ox + X_W'(p % SW);
      e.y = oy + Y_W'(p / SW);
      e.c = c;
      if (!(TEN && !erase && !fill && c == TRANSP)) q.push_back(e);
    end
  endtask

  // issue one request; returns at the negedge where oDone must be showing
  task automatic request(logic [1:0] mode, logic [X_W-1:0] x, logic [Y_W-1:0] y,
                         logic [CW-1:0] colour, bit early, bit poke);
    int k, pcount;
    exp_t d;
    if (!early) @(negedge clock);
    bus.iStart = 1'b1; bus.iMode = mode; bus.iX = x; bus.iY = y; bus.iColour = colour;
    k = early ? cyc + 2 : cyc + 1;
    pcount = (mode == 2'd2) ? 2*N : N;
    case (mode)
      2'd0: push_pass(1'b0, 1'b0, x, y, colour, k + 1);
      2'd1: push_pass(1'b1, 1'b0, x, y, colour, k + 1);
      2'd2: begin
        push_pass(1'b1, 1'b0, prev_x, prev_y, colour, k + 1);
        push_pass(1'b0, 1'b0, x, y, colour, k + 1 + N);
      end
      default: push_pass(1'b0, 1'b1, x, y, colour, k + 1);
    endcase
    d.cyc = k + pcount + 1; d.done = 1'b1; d.x = '0; d.y = '0; d.c = '0;
    q.push_back(d);
    k_start = k; done_cyc = k + pcount + 1;
    if (mode != 2'd1) begin prev_x = x; prev_y = y; end
    if (early) @(negedge clock);
    @(negedge clock);
    bus.iStart = 1'b0;
    bus.iMode = 2'($urandom); bus.iX = X_W'($urandom); bus.iY = Y_W'($urandom);
    bus.iColour = CW'($urandom);
    if (poke) begin
      repeat (3) @(negedge clock);
      bus.iStart = 1'b1;
      @(negedge clock);
      bus.iStart = 1'b0;
    end
    while (cyc < done_cyc) @(negedge clock);
  endtask

  // monitor: compare every plot/done against the scoreboard head, plus oBusy
  always @(negedge clock) begin
    if (reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missing output: cyc %0d expected done=%0d at cyc %0d", cyc, q[0].done, q[0].cyc);
        void'(q.pop_front());
      end
      if (bus.oPlot && bus.oDone) begin
        tests++; fails++;
        $display("FAIL plot_and_done: both high at cyc %0d, required exclusive", cyc);
      end else if (bus.oPlot || bus.oDone) begin
        tests++;
        if (q.size() > 0 && q[0].cyc == cyc && q[0].done == bus.oDone) begin
          if (bus.oPlot && (bus.oX !== q[0].x || bus.oY !== q[0].y || bus.oColour !== q[0].c)) begin
            fails++;
            $display("FAIL pixel: cyc %0d got (%0d,%0d) c%0d expected (%0d,%0d) c%0d",
                     cyc, bus.oX, bus.oY, bus.oColour, q[0].x, q[0].y, q[0].c);
          end
          void'(q.pop_front());
        end else begin
          fails++;
          $display("FAIL unexpected output: cyc %0d plot=%0d done=%0d, scoreboard size %0d",
                   cyc, bus.oPlot, bus.oDone, q.size());
        end
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        tests++; fails++;
        $display("FAIL missing output: cyc %0d expected done=%0d, got plot=0 done=0", cyc, q[0].done);
        void'(q.pop_front());
      end
      tests++;
      if (bus.oBusy !== (cyc >= k_start && cyc < done_cyc)) begin
        fails++;
        $display("FAIL busy: cyc %0d got %0d expected %0d", cyc, bus.oBusy,
                 (cyc >= k_start && cyc < done_cyc));
      end
    end
  end

  task automatic check_all_zero(string tag);
    check({tag, "_oX"}, int'(bus.oX), 0);
    check({tag, "_oY"}, int'(bus.oY), 0);
    check({tag, "_oColour"}, int'(bus.oColour), 0);
    check({tag, "_oPixAddr"}, int'(bus.oPixAddr), 0);
    check({tag, "_oPlot"}, int'(bus.oPlot), 0);
    check({tag, "_oBusy"}, int'(bus.oBusy), 0);
    check({tag, "_oDone"}, int'(bus.oDone), 0);
  endtask

  initial begin
    int k;
    bus.iStart = 1'b0; bus.iMode = 2'd0; bus.iX = '0; bus.iY = '0; bus.iColour = '0;
    for (int a = 0; a < N; a++) rom[a] = CW'(a % 8);
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    request(2'd3, 8'd10, 7'd20, 3'd3, 1'b0, 1'b0);    // FILL
    request(2'd2, 8'd50, 7'd60, 3'd1, 1'b0, 1'b0);    // MOVE from (10,20)
    request(2'd0, 8'd30, 7'd40, 3'd6, 1'b0, 1'b0);    // DRAW, ROM = addr mod 8
    request(2'd1, 8'd5,  7'd6,  3'd6, 1'b0, 1'b0);    // ERASE, prev stays (30,40)
    request(2'd2, 8'd70, 7'd80, 3'd2, 1'b0, 1'b0);    // MOVE from (30,40)
    request(2'd3, 8'd254, 7'd126, 3'd5, 1'b0, 1'b1);  // wrap, iStart poked while busy
    request(2'd3, 8'd1, 7'd2, 3'd7, 1'b1, 1'b0);      // iStart held through DONE
    rom[5] = 3'd0;
    request(2'd0, 8'd100, 7'd9, 3'd0, 1'b0, 1'b0);    // zero pixel at addr 5

    // reset during pixel 7 of a FILL pass abandons it without oDone
    @(negedge clock);
    bus.iStart = 1'b1; bus.iMode = 2'd3; bus.iX = 8'd90; bus.iY = 7'd30; bus.iColour = 3'd4;
    k = cyc + 1;
    push_pass(1'b0, 1'b1, 8'd90, 7'd30, 3'd4, k + 1);
    k_start = k; done_cyc = k + N + 1;
    @(negedge clock);
    bus.iStart = 1'b0;
    while (cyc < k + 8) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    q.delete();
    k_start = 0; done_cyc = 0; prev_x = '0; prev_y = '0;
    @(negedge clock);
    check_all_zero("abort");
    reset = 1'b1;
    repeat (4) @(negedge clock);
    request(2'd2, 8'd20, 7'd25, 3'd0, 1'b0, 1'b0);    // MOVE from reset prev (0,0)

    for (int i = 0; i < 24; i++) begin
      for (int a = 0; a < N; a++) rom[a] = CW'($urandom);
      request(2'($urandom), X_W'($urandom), Y_W'($urandom), CW'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clock);
    check("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
